// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the EX-stage ALU.
//   - ALU_op encodings driven by the main control unit
//   - R-type funct codes understood by the unit
//   - Top-level FSM state and internal operation-select enums
//   - decode_op(): collapses ALU_op/funct into a single op_e
package alu_pkg;

   // ALU_op encodings from the main decoder
   localparam logic [1:0] ALU_OP_ADD   = 2'b00;  // lw/sw address add
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;  // beq/bne compare
   localparam logic [1:0] ALU_OP_RTYPE = 2'b10;  // use funct field
   localparam logic [1:0] ALU_OP_SLT   = 2'b11;  // slti

   // R-type funct codes
   localparam logic [5:0] FUNCT_SLL   = 6'b000000;
   localparam logic [5:0] FUNCT_SRL   = 6'b000010;
   localparam logic [5:0] FUNCT_SRA   = 6'b000011;
   localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
   localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
   localparam logic [5:0] FUNCT_MULT  = 6'b011000;
   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_DIV   = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
   localparam logic [5:0] FUNCT_ADD   = 6'b100000;
   localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
   localparam logic [5:0] FUNCT_SUB   = 6'b100010;
   localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
   localparam logic [5:0] FUNCT_AND   = 6'b100100;
   localparam logic [5:0] FUNCT_OR    = 6'b100101;
   localparam logic [5:0] FUNCT_XOR   = 6'b100110;
   localparam logic [5:0] FUNCT_NOR   = 6'b100111;
   localparam logic [5:0] FUNCT_SLT   = 6'b101010;
   localparam logic [5:0] FUNCT_SLTU  = 6'b101011;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDone
   } state_e;

   typedef enum logic [4:0] {
      OpAnd,
      OpOr,
      OpXor,
      OpNor,
      OpAdd,
      OpSub,
      OpSlt,
      OpSltu,
      OpSll,
      OpSrl,
      OpSra,
      OpMfhi,
      OpMflo,
      OpMul,
      OpMulu,
      OpDiv,
      OpDivu,
      OpIll
   } op_e;

   // Signed and unsigned add/sub share one op; the overflow check tells them apart.
   function automatic op_e decode_op(input logic [1:0] alu_op, input logic [5:0] funct);
      op_e op;
      op = OpIll;
      case (alu_op)
         ALU_OP_ADD: op = OpAdd;
         ALU_OP_SUB: op = OpSub;
         ALU_OP_SLT: op = OpSlt;
         default: begin
            case (funct)
               FUNCT_AND:              op = OpAnd;
               FUNCT_OR:               op = OpOr;
               FUNCT_XOR:              op = OpXor;
               FUNCT_NOR:              op = OpNor;
               FUNCT_ADD, FUNCT_ADDU:  op = OpAdd;
               FUNCT_SUB, FUNCT_SUBU:  op = OpSub;
               FUNCT_SLT:              op = OpSlt;
               FUNCT_SLTU:             op = OpSltu;
               FUNCT_SLL:              op = OpSll;
               FUNCT_SRL:              op = OpSrl;
               FUNCT_SRA:              op = OpSra;
               FUNCT_MFHI:             op = OpMfhi;
               FUNCT_MFLO:             op = OpMflo;
               FUNCT_MULT:             op = OpMul;
               FUNCT_MULTU:            op = OpMulu;
               FUNCT_DIV:              op = OpDiv;
               FUNCT_DIVU:             op = OpDivu;
               default:                op = OpIll;
            endcase
         end
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative multiply / restoring divide, one bit per cycle.
// A start pulse latches the operands; exactly WIDTH cycles later done pulses for one
// cycle and hi/lo carry the final values (valid only while done is high).
// Ports:
//   clk, reset        clock, synchronous active-high reset (aborts any operation)
//   start             launch an operation (only while idle)
//   is_div, is_signed operation select, sampled with start
//   op_a, op_b        multiplicand/multiplier or dividend/divisor, sampled with start
//   done              one-cycle completion pulse
//   hi, lo            product {hi,lo}, or remainder (hi) / quotient (lo)
module alu_muldiv_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_div,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   logic             busy_q, busy_d;
   logic             div_q, div_d;
   logic             neg_a_q, neg_a_d;
   logic             neg_b_q, neg_b_d;
   logic             dbz_q, dbz_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;  // product high half / partial remainder
   logic [WIDTH-1:0] q_q, q_d;      // multiplier / dividend shifting into quotient
   logic [WIDTH-1:0] m_q, m_d;      // multiplicand / divisor magnitude

   logic             sign_a, sign_b;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   rshift;
   logic             rge;
   logic [WIDTH-1:0] rsub;
   logic [WIDTH-1:0] acc_n, q_n;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   // Signed operations run on magnitudes; signs are re-applied at the end.
   assign sign_a = is_signed & op_a[WIDTH-1];
   assign sign_b = is_signed & op_b[WIDTH-1];
   assign mag_a  = sign_a ? -op_a : op_a;
   assign mag_b  = sign_b ? -op_b : op_b;

   // One iteration step
   assign mul_sum = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);
   assign rshift  = {acc_q, q_q[WIDTH-1]};
   assign rge     = (rshift >= {1'b0, m_q});
   // Partial remainder stays below the divisor, so the low WIDTH bits suffice.
   assign rsub    = rshift[WIDTH-1:0] - m_q;

   always_comb begin
      acc_n = mul_sum[WIDTH:1];
      q_n   = {mul_sum[0], q_q[WIDTH-1:1]};
      if (div_q) begin
         acc_n = rge ? rsub : rshift[WIDTH-1:0];
         q_n   = {q_q[WIDTH-2:0], rge};
      end
   end

   // Final sign fix-up, applied to the last step's values so done can coincide with it
   assign prod     = {acc_n, q_n};
   assign prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;
   // Divide by zero: quotient forced to all ones; remainder naturally equals the dividend.
   assign quo_fix  = dbz_q ? '1 : ((neg_a_q ^ neg_b_q) ? -q_n : q_n);
   assign rem_fix  = neg_a_q ? -acc_n : acc_n;

   assign done = busy_q && (cnt_q == LAST);
   assign hi   = div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
   assign lo   = div_q ? quo_fix : prod_fix[WIDTH-1:0];

   always_comb begin
      busy_d  = busy_q;
      div_d   = div_q;
      neg_a_d = neg_a_q;
      neg_b_d = neg_b_q;
      dbz_d   = dbz_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      q_d     = q_q;
      m_d     = m_q;
      if (start) begin
         busy_d  = 1'b1;
         div_d   = is_div;
         neg_a_d = sign_a;
         neg_b_d = sign_b;
         dbz_d   = is_div && (op_b == '0);
         cnt_d   = '0;
         acc_d   = '0;
         q_d     = mag_a;
         m_d     = mag_b;
      end else if (busy_q) begin
         acc_d = acc_n;
         q_d   = q_n;
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LAST) begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q  <= 1'b0;
         div_q   <= 1'b0;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         dbz_q   <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         m_q     <= '0;
      end else begin
         busy_q  <= busy_d;
         div_q   <= div_d;
         neg_a_q <= neg_a_d;
         neg_b_q <= neg_b_d;
         dbz_q   <= dbz_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         m_q     <= m_d;
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU with merged ALU_op/funct decode, registered single-cycle
// datapath, and an iterative mult/div engine writing HI/LO.
// Optional build macro: ALU_OVERFLOW_TRAP_EN adds the 'overflow' output, flagging
// signed add/sub overflow (addu/subu never flag).
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid, in_ready  request handshake; in_ready is low while mult/div is busy
//   ALU_op, ALU_funct   operation select (ALU_op 10 uses funct)
//   shamt               shift amount for sll/srl/sra (shifts operate on src_b)
//   src_a, src_b        operands (rs, rt/imm)
//   out_valid           one-cycle pulse with each result
//   result, zero        registered result and result==0 flag
//   overflow            (ALU_OVERFLOW_TRAP_EN only) signed add/sub overflow
//   illegal             unrecognised funct
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         ALU_op,
   input  logic [5:0]         ALU_funct,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [WIDTH-1:0]   src_a,
   input  logic [WIDTH-1:0]   src_b,
   output logic               out_valid,
   output logic [WIDTH-1:0]   result,
   output logic               zero,
`ifdef ALU_OVERFLOW_TRAP_EN
   output logic               overflow,
`endif
   output logic               illegal
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             illegal_q, illegal_d;
   logic             out_valid_q, out_valid_d;

   op_e              op;
   logic             accept;
   logic             is_multi;
   logic             md_start, md_done;
   logic [WIDTH-1:0] md_hi, md_lo;
   logic [WIDTH-1:0] sum, diff, alu_res;

   assign op       = decode_op(ALU_op, ALU_funct);
   assign in_ready = (state_q != StBusy);
   assign accept   = in_valid && in_ready;
   assign is_multi = op inside {OpMul, OpMulu, OpDiv, OpDivu};
   assign md_start = accept && is_multi;

   assign sum  = src_a + src_b;
   assign diff = src_a - src_b;

   // Single-cycle datapath; mfhi/mflo read the registered HI/LO, which in DONE
   // already hold the just-finished mult/div values.
   always_comb begin
      alu_res = '0;
      case (op)
         OpAnd:   alu_res = src_a & src_b;
         OpOr:    alu_res = src_a | src_b;
         OpXor:   alu_res = src_a ^ src_b;
         OpNor:   alu_res = ~(src_a | src_b);
         OpAdd:   alu_res = sum;
         OpSub:   alu_res = diff;
         OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
         OpSll:   alu_res = src_b << shamt;
         OpSrl:   alu_res = src_b >> shamt;
         OpSra:   alu_res = $unsigned($signed(src_b) >>> shamt);
         OpMfhi:  alu_res = hi_q;
         OpMflo:  alu_res = lo_q;
         default: alu_res = '0;
      endcase
   end

`ifdef ALU_OVERFLOW_TRAP_EN
   logic overflow_q, overflow_d;
   logic trap_chk, ovf_res;

   // addu/subu decode to the same ops as add/sub but must never trap
   assign trap_chk = !((ALU_op == ALU_OP_RTYPE) &&
                       ((ALU_funct == FUNCT_ADDU) || (ALU_funct == FUNCT_SUBU)));

   always_comb begin
      ovf_res = 1'b0;
      if (op == OpAdd) begin
         ovf_res = trap_chk && (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                   (sum[WIDTH-1] != src_a[WIDTH-1]);
      end else if (op == OpSub) begin
         ovf_res = trap_chk && (src_a[WIDTH-1] != src_b[WIDTH-1]) &&
                   (diff[WIDTH-1] != src_a[WIDTH-1]);
      end
   end
`endif

   alu_muldiv_iter #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .clk       (clk),
      .reset     (reset),
      .start     (md_start),
      .is_div    (op inside {OpDiv, OpDivu}),
      .is_signed (op inside {OpMul, OpDiv}),
      .op_a      (src_a),
      .op_b      (src_b),
      .done      (md_done),
      .hi        (md_hi),
      .lo        (md_lo)
   );

   // FSM next state and registered outputs
   always_comb begin
      state_d     = state_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      result_d    = result_q;
      zero_d      = zero_q;
      illegal_d   = illegal_q;
      out_valid_d = 1'b0;
`ifdef ALU_OVERFLOW_TRAP_EN
      overflow_d  = overflow_q;
`endif
      case (state_q)
         StBusy: begin
            if (md_done) begin
               state_d     = StDone;
               hi_d        = md_hi;
               lo_d        = md_lo;
               result_d    = md_lo;
               zero_d      = (md_lo == '0);
               illegal_d   = 1'b0;
               out_valid_d = 1'b1;
`ifdef ALU_OVERFLOW_TRAP_EN
               overflow_d  = 1'b0;
`endif
            end
         end
         default: begin
            // StIdle and StDone both accept; the unused encoding recovers to StIdle.
            state_d = StIdle;
            if (accept) begin
               if (is_multi) begin
                  state_d = StBusy;
               end else begin
                  result_d    = alu_res;
                  zero_d      = (alu_res == '0);
                  illegal_d   = (op == OpIll);
                  out_valid_d = 1'b1;
`ifdef ALU_OVERFLOW_TRAP_EN
                  overflow_d  = ovf_res;
`endif
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         hi_q        <= '0;
         lo_q        <= '0;
         result_q    <= '0;
         zero_q      <= 1'b1;
         illegal_q   <= 1'b0;
         out_valid_q <= 1'b0;
`ifdef ALU_OVERFLOW_TRAP_EN
         overflow_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         illegal_q   <= illegal_d;
         out_valid_q <= out_valid_d;
`ifdef ALU_OVERFLOW_TRAP_EN
         overflow_q  <= overflow_d;
`endif
      end
   end

   assign result    = result_q;
   assign zero      = zero_q;
   assign illegal   = illegal_q;
   assign out_valid = out_valid_q;
`ifdef ALU_OVERFLOW_TRAP_EN
   assign overflow  = overflow_q;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit (WIDTH = 32): directed vectors push their expected
// response; a negedge monitor pops and compares whenever out_valid is high.
module tb_alu_exec_unit;

   localparam logic [5:0] F_SLL  = 6'b000000;
   localparam logic [5:0] F_SRL  = 6'b000010;
   localparam logic [5:0] F_SRA  = 6'b000011;
   localparam logic [5:0] F_MFHI = 6'b010000;
   localparam logic [5:0] F_MFLO = 6'b010010;
   localparam logic [5:0] F_MULT = 6'b011000;
   localparam logic [5:0] F_MULU = 6'b011001;
   localparam logic [5:0] F_DIV  = 6'b011010;
   localparam logic [5:0] F_DIVU = 6'b011011;
   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_ADDU = 6'b100001;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_SUBU = 6'b100011;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_XOR  = 6'b100110;
   localparam logic [5:0] F_NOR  = 6'b100111;
   localparam logic [5:0] F_SLT  = 6'b101010;
   localparam logic [5:0] F_SLTU = 6'b101011;
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_R   = 2'b10;
   localparam logic [1:0] OP_SLT = 2'b11;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  alu_op;
   logic [5:0]  funct;
   logic [4:0]  shamt;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        out_valid;
   logic [31:0] result;
   logic        zero;
   logic        illegal;
`ifdef ALU_OVERFLOW_TRAP_EN
   logic        overflow;
`endif

   typedef struct packed {
      logic [31:0] res;
      logic        zero;
      logic        ill;
      logic        ovf;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   exp_t  mon_e;
   string mon_nm;
   int    n_tests = 0;
   int    n_fail = 0;
   int    busy_cycles;
   int    ov_cycle;
   int    ov_seen;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   alu_exec_unit #(
      .WIDTH (32)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ALU_op    (alu_op),
      .ALU_funct (funct),
      .shamt     (shamt),
      .src_a     (src_a),
      .src_b     (src_b),
      .out_valid (out_valid),
      .result    (result),
      .zero      (zero),
`ifdef ALU_OVERFLOW_TRAP_EN
      .overflow  (overflow),
`endif
      .illegal   (illegal)
   );

   function automatic void check(input string nm, input logic [31:0] act,
                                 input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, req);
      end
   endfunction

   function automatic void push(input string nm, input logic [31:0] res, input logic ill,
                                input logic ovf);
      exp_t e;
      e.res  = res;
      e.zero = (res == 32'h0);
      e.ill  = ill;
      e.ovf  = ovf;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endfunction

   // Monitor: every out_valid pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out_valid: got result 0x%08h, required no output", result);
         end else begin
            mon_e  = exp_q.pop_front();
            mon_nm = name_q.pop_front();
            check({mon_nm, ".result"}, result, mon_e.res);
            check({mon_nm, ".zero"}, {31'b0, zero}, {31'b0, mon_e.zero});
            check({mon_nm, ".illegal"}, {31'b0, illegal}, {31'b0, mon_e.ill});
`ifdef ALU_OVERFLOW_TRAP_EN
            check({mon_nm, ".overflow"}, {31'b0, overflow}, {31'b0, mon_e.ovf});
`endif
         end
      end
   end

   task automatic wait_ready(input int budget);
      int k;
      k = 0;
      while (in_ready !== 1'b1 && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (in_ready !== 1'b1) begin
         n_tests++;
         n_fail++;
         $display("FAIL ready_timeout: in_ready=%b after %0d cycles, required 1", in_ready, budget);
      end
   endtask

   // Drive one request; returns #1 after the accepting edge.
   task automatic send(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b);
      wait_ready(64);
      alu_op   = op;
      funct    = fn;
      shamt    = sh;
      src_a    = a;
      src_b    = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic op_exp(input string nm, input logic [1:0] op, input logic [5:0] fn,
                         input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic ill, input logic ovf);
      push(nm, res, ill, ovf);
      send(op, fn, sh, a, b);
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      alu_op   = 2'b00;
      funct    = 6'b0;
      shamt    = 5'd0;
      src_a    = 32'h0;
      src_b    = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      check("rst.in_ready", {31'b0, in_ready}, 32'd1);
      check("rst.out_valid", {31'b0, out_valid}, 32'd0);
      check("rst.result", result, 32'h0);
      check("rst.zero", {31'b0, zero}, 32'd1);
      check("rst.illegal", {31'b0, illegal}, 32'd0);
      op_exp("rst_mfhi", OP_R, F_MFHI, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      op_exp("rst_mflo", OP_R, F_MFLO, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

      // Back-to-back single-cycle ops
      op_exp("add_ovf", OP_R, F_ADD, 5'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1);
      op_exp("sub_zero", OP_SUB, 6'b0, 5'd0, 32'h1234, 32'h1234, 32'h0, 1'b0, 1'b0);
      op_exp("sltu", OP_R, F_SLTU, 5'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0);
      op_exp("slt", OP_R, F_SLT, 5'd0, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1'b0);
      op_exp("slti", OP_SLT, 6'b0, 5'd0, 32'hFFFFFFFB, 32'h3, 32'h1, 1'b0, 1'b0);
      op_exp("lw_add_wrap", OP_ADD, 6'b0, 5'd0, 32'h80000000, 32'h80000000, 32'h0, 1'b0, 1'b1);
      op_exp("addu", OP_R, F_ADDU, 5'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b0);
      op_exp("subu", OP_R, F_SUBU, 5'd0, 32'h0, 32'h1, 32'hFFFFFFFF, 1'b0, 1'b0);
      op_exp("sub_ovf", OP_R, F_SUB, 5'd0, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b0, 1'b1);
      check("b2b.in_ready", {31'b0, in_ready}, 32'd1);
      op_exp("and", OP_R, F_AND, 5'd0, 32'hF0F01234, 32'h0FF0FFFF, 32'h00F01234, 1'b0, 1'b0);
      op_exp("or", OP_R, F_OR, 5'd0, 32'hF0F01234, 32'h0FF0FFFF, 32'hFFF0FFFF, 1'b0, 1'b0);
      op_exp("xor", OP_R, F_XOR, 5'd0, 32'hF0F01234, 32'h0FF0FFFF, 32'hFF00EDCB, 1'b0, 1'b0);
      op_exp("nor", OP_R, F_NOR, 5'd0, 32'hF0F01234, 32'h0FF0FFFF, 32'h000F0000, 1'b0, 1'b0);
      op_exp("sll", OP_R, F_SLL, 5'd31, 32'h0, 32'h1, 32'h80000000, 1'b0, 1'b0);
      op_exp("srl", OP_R, F_SRL, 5'd4, 32'h0, 32'h80000000, 32'h08000000, 1'b0, 1'b0);
      op_exp("sra", OP_R, F_SRA, 5'd4, 32'h0, 32'h80000000, 32'hF8000000, 1'b0, 1'b0);

      // Signed divide -7 / 2: check stall length, result cycle, and ignored in_valid
      op_exp("div_m7_2", OP_R, F_DIV, 5'd0, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 1'b0, 1'b0);
      busy_cycles = 0;
      ov_cycle = 0;
      for (int k = 1; k <= 40; k++) begin
         if (in_ready === 1'b0) busy_cycles++;
         if (out_valid === 1'b1 && ov_cycle == 0) ov_cycle = k;
         if (k == 10) begin
            alu_op   = OP_R;
            funct    = F_ADD;
            src_a    = 32'h1;
            src_b    = 32'h1;
            in_valid = 1'b1;
         end
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
      check("div.busy_cycles", 32'(busy_cycles), 32'd32);
      check("div.out_valid_cycle", 32'(ov_cycle), 32'd33);
      op_exp("div_mfhi", OP_R, F_MFHI, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0);

      // Divide by zero, then read HI while still in DONE
      op_exp("divu_by0", OP_R, F_DIVU, 5'd0, 32'h12345678, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0);
      wait_ready(64);
      check("divu.done_out_valid", {31'b0, out_valid}, 32'd1);
      op_exp("divu_mfhi_in_done", OP_R, F_MFHI, 5'd0, 32'h0, 32'h0, 32'h12345678, 1'b0, 1'b0);
      op_exp("divu_mflo", OP_R, F_MFLO, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0);

      op_exp("multu", OP_R, F_MULU, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0);
      op_exp("multu_mfhi", OP_R, F_MFHI, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFE, 1'b0, 1'b0);

      // Illegal funct leaves HI/LO alone
      op_exp("illegal", OP_R, 6'b111111, 5'd0, 32'h5, 32'h6, 32'h0, 1'b1, 1'b0);
      op_exp("ill_mfhi", OP_R, F_MFHI, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFE, 1'b0, 1'b0);
      op_exp("ill_mflo", OP_R, F_MFLO, 5'd0, 32'h0, 32'h0, 32'h1, 1'b0, 1'b0);

      op_exp("mult_m3_5", OP_R, F_MULT, 5'd0, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFF1, 1'b0, 1'b0);
      op_exp("mult_mfhi", OP_R, F_MFHI, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0);
      op_exp("div_min_m1", OP_R, F_DIV, 5'd0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0,
             1'b0);
      op_exp("div_min_mfhi", OP_R, F_MFHI, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      op_exp("div_7_m2", OP_R, F_DIV, 5'd0, 32'h7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b0);
      op_exp("div_7_m2_mfhi", OP_R, F_MFHI, 5'd0, 32'h0, 32'h0, 32'h1, 1'b0, 1'b0);

      // Reset in BUSY cycle 10 aborts the divide; no result expected
      send(OP_R, F_DIVU, 5'd0, 32'd100, 32'd7);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      check("abort.busy", {31'b0, in_ready}, 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("abort.in_ready", {31'b0, in_ready}, 32'd1);
      check("abort.result", result, 32'h0);
      check("abort.zero", {31'b0, zero}, 32'd1);
      ov_seen = 0;
      for (int k = 0; k < 40; k++) begin
         if (out_valid === 1'b1) ov_seen = 1;
         @(posedge clk);
         #1;
      end
      check("abort.no_out_valid", 32'(ov_seen), 32'd0);
      op_exp("abort_mfhi", OP_R, F_MFHI, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      op_exp("abort_mflo", OP_R, F_MFLO, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
